// File: rtl/multiword_add_seq.sv
// Multi-limb adder sequencer around a 32-bit CLA.
// Ports: clk, rst_n, in_valid/in_ready/in_a/in_b, out_valid/out_ready/out_sum/out_last/out_cout, busy.
module bitmodifiedcarrylook (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;
  logic [8:0]  cg;
  logic        gg;
  logic        gp;

  assign g = a & b;
  assign p = a ^ b;

  // 4-bit lookahead groups, group carries chained by group G/P
  always_comb begin
    c  = '0;
    cg = '0;
    gg = 1'b0;
    gp = 1'b0;
    for (int j = 0; j < 8; j++) begin
      c[4*j]   = cg[j];
      c[4*j+1] = g[4*j]
               | (p[4*j] & cg[j]);
      c[4*j+2] = g[4*j+1]
               | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & cg[j]);
      c[4*j+3] = g[4*j+2]
               | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1]
                  & p[4*j] & cg[j]);
      gg = g[4*j+3]
         | (p[4*j+3] & g[4*j+2])
         | (p[4*j+3] & p[4*j+2] & g[4*j+1])
         | (p[4*j+3] & p[4*j+2]
            & p[4*j+1] & g[4*j]);
      gp = &p[4*j +: 4];
      cg[j+1] = gg | (gp & cg[j]);
    end
    c[32] = cg[8];
  end

  assign sum  = p ^ c[31:0];
  assign cout = c[32];
endmodule

module multiword_add_seq #(
  parameter int LIMBS = 4,
  parameter int CW    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        out_last,
  output logic        out_cout,
  output logic        busy
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [CW-1:0] idx;
  logic        carry;
  logic        acc;
  logic        idx_last;
  logic        cin;
  logic [31:0] s1;
  logic        c1;
  logic [31:0] s;
  logic        c2;
  logic        lc;

  bitmodifiedcarrylook u_cla (
    .a    (in_a),
    .b    (in_b),
    .sum  (s1),
    .cout (c1)
  );

  // In LAST out_valid is always set, so this also
  // gives in_ready = out_ready there.
  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  assign idx_last = (idx == CW'(LIMBS - 1));
  assign cin      = (idx == '0) ? 1'b0 : carry;
  assign s        = s1 + {31'd0, cin};
  assign c2       = (&s1) & cin;
  assign lc       = c1 | c2;
  assign busy     = (state != IDLE);

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (acc) state_d = idx_last ? LAST : RUN;
      end
      RUN: begin
        if (acc && idx_last) state_d = LAST;
      end
      LAST: begin
        if (out_ready) begin
          if (acc) state_d = idx_last ? LAST : RUN;
          else     state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
    end else begin
      state <= state_d;
      if (acc) begin
        out_valid <= 1'b1;
        out_sum   <= s;
        out_last  <= idx_last;
        out_cout  <= idx_last & lc;
        carry     <= lc;
        idx       <= idx_last ? '0 : idx + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        out_cout  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq: 128-bit reference model
// plus directed literal checks and random streams.
module tb_multiword_add_seq;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_last;
  logic        out_cout;
  logic        busy;

  logic dir_ready = 1'b1;
  logic rnd_bit = 1'b1;
  logic rnd_en = 1'b0;
  assign out_ready = rnd_en ? rnd_bit : dir_ready;

  int errors = 0;
  int checks = 0;

  logic [33:0] expq[$];
  logic [33:0] obsq[$];
  logic [33:0] got[$];
  logic [31:0] ba[L];
  logic [31:0] bb[L];
  int          nbuf = 0;

  logic        pv, pr, pl, pc, have_prev = 1'b0;
  logic [31:0] ps;

  multiword_add_seq #(.LIMBS(L), .CW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Reference model: whole-operand arithmetic per op
  always @(negedge clk) begin
    logic [128:0] r;
    logic [127:0] ra, rb;
    logic [33:0]  e, o;
    if (!rst_n) begin
      expq.delete();
      obsq.delete();
      got.delete();
      nbuf = 0;
      have_prev = 1'b0;
    end else begin
      if (have_prev && pv && !pr) begin
        chk("hold", {out_valid, out_sum, out_last, out_cout},
            {1'b1, ps, pl, pc});
      end
      if (out_valid && !out_last)
        chk("cout_nonlast", {63'd0, out_cout}, 64'd0);
      if (out_valid && out_ready) begin
        obsq.push_back({out_sum, out_last, out_cout});
        got.push_back({out_sum, out_last, out_cout});
      end
      if (in_valid && in_ready) begin
        ba[nbuf] = in_a;
        bb[nbuf] = in_b;
        nbuf++;
        if (nbuf == L) begin
          for (int k = 0; k < L; k++) begin
            ra[32*k +: 32] = ba[k];
            rb[32*k +: 32] = bb[k];
          end
          r = {1'b0, ra} + {1'b0, rb};
          for (int k = 0; k < L; k++)
            expq.push_back({r[32*k +: 32], k == L-1,
                            (k == L-1) ? r[128] : 1'b0});
          nbuf = 0;
        end
      end
      while (expq.size() > 0 && obsq.size() > 0) begin
        e = expq.pop_front();
        o = obsq.pop_front();
        chk("stream", {30'd0, o}, {30'd0, e});
      end
      pv = out_valid;
      pr = out_ready;
      ps = out_sum;
      pl = out_last;
      pc = out_cout;
      have_prev = 1'b1;
    end
  end

  // Called at posedge+1; returns at posedge+1 after accept
  task automatic send(input logic [31:0] a,
                      input logic [31:0] b);
    int t;
    logic ok;
    t = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      t++;
      if (t > 60) begin
        chk("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (out_valid || expq.size() != 0
           || obsq.size() != 0) begin
      @(posedge clk);
      #1;
      t++;
      if (t > 60) begin
        chk("drain_timeout", 64'd1, 64'd0);
        break;
      end
    end
  endtask

  task automatic send_op(input logic [127:0] a,
                         input logic [127:0] b,
                         input int gap);
    for (int k = 0; k < L; k++) begin
      repeat (gap > 0 ? $urandom_range(0, gap) : 0)
        @(posedge clk);
      if (gap > 0) #1;
      send(a[32*k +: 32], b[32*k +: 32]);
    end
  endtask

  function automatic logic [31:0] rlimb();
    case ($urandom_range(0, 3))
      0: return 32'hFFFFFFFF;
      1: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [127:0] a, b;
    // 1. reset and idle
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_outs", {out_valid, out_sum, out_last,
                     out_cout, busy}, 64'd0);

    // 2. all ones + 1
    @(posedge clk); #1;
    got.delete();
    send_op({4{32'hFFFFFFFF}}, 128'd1, 0);
    drain();
    chk("t2_n", got.size(), 4);
    if (got.size() == 4) begin
      chk("t2_l0", {30'd0, got[0]}, {30'd0, 32'h0, 2'b00});
      chk("t2_l1", {30'd0, got[1]}, {30'd0, 32'h0, 2'b00});
      chk("t2_l2", {30'd0, got[2]}, {30'd0, 32'h0, 2'b00});
      chk("t2_l3", {30'd0, got[3]}, {30'd0, 32'h0, 2'b11});
    end

    // 3. simple op, 1-cycle latency
    got.delete();
    send(32'h1, 32'h1);
    @(negedge clk);
    chk("t3_lat0", {out_valid, out_sum},
        {1'b1, 32'h2});
    chk("t3_busy", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    send(32'h11110002, 32'h11110002);
    @(negedge clk);
    chk("t3_lat1", {out_valid, out_sum},
        {1'b1, 32'h22220004});
    @(posedge clk); #1;
    send(32'h0, 32'h0);
    send(32'h0, 32'h0);
    @(negedge clk);
    chk("t3_last", {out_valid, out_last, out_cout, out_sum},
        {3'b110, 32'h0});
    @(posedge clk); #1;
    drain();
    chk("t3_idle", {62'd0, busy, out_valid}, 64'd0);

    // 4. backpressure after limb 1
    got.delete();
    send(32'hFFFFFFFF, 32'h00000002);
    send(32'h80000000, 32'h80000000);
    dir_ready = 1'b0;
    in_valid = 1'b1;
    in_a = 32'h12345678;
    in_b = 32'h0;
    repeat (3) begin
      @(negedge clk);
      chk("t4_stall", {in_ready, out_valid, out_sum},
          {2'b01, 32'h00000001});
      @(posedge clk); #1;
    end
    dir_ready = 1'b1;
    send(32'h12345678, 32'h0);
    send(32'h0, 32'h0);
    drain();
    chk("t4_n", got.size(), 4);
    if (got.size() == 4) begin
      chk("t4_l0", got[0][33:2], 32'h00000001);
      chk("t4_l1", got[1][33:2], 32'h00000001);
      chk("t4_l2", got[2][33:2], 32'h12345679);
      chk("t4_l3", {30'd0, got[3]}, {30'd0, 32'h0, 2'b10});
    end

    // 5. back-to-back, carry must not leak
    got.delete();
    send_op({4{32'hFFFFFFFF}}, 128'd1, 0);
    send_op(128'd0, 128'd0, 0);
    drain();
    chk("t5_n", got.size(), 8);
    if (got.size() == 8) begin
      chk("t5_c1", {62'd0, got[3][1:0]}, 64'd3);
      chk("t5_op2l0", {30'd0, got[4]}, 64'd0);
      chk("t5_c2", {30'd0, got[7]}, {30'd0, 32'h0, 2'b10});
    end

    // 6. reset mid-op
    send(32'hFFFFFFFF, 32'h1);
    send(32'hFFFFFFFF, 32'h0);
    send(32'hFFFFFFFF, 32'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_rst", {in_ready, out_valid, out_sum,
                   out_last, out_cout, busy},
        {1'b1, 36'd0});
    @(posedge clk); #1;
    got.delete();
    send_op(128'd1, 128'd1, 0);
    drain();
    chk("t6_n", got.size(), 4);
    if (got.size() == 4)
      chk("t6_l0", {30'd0, got[0]}, {30'd0, 32'h2, 2'b00});

    // random streams with gaps and backpressure
    rnd_en = 1'b1;
    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < L; k++) begin
        a[32*k +: 32] = rlimb();
        b[32*k +: 32] = rlimb();
      end
      send_op(a, b, 2);
    end
    rnd_en = 1'b0;
    drain();
    chk("end_nbuf", nbuf, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
